byte_fetch_unit: RTL and testbench

- Fetch-side driver for the byte-serial instruction path.
- Issues byte reads to the 8-bit instruction RAM (1-cycle read latency) and presents one instruction byte per cycle to the IF/ID byte assembler as if_inst/if_pc.
- Honours the assembler's if_request flow control and redirects on jump.
- Sits between the instruction RAM port and the IF/ID register.

---
 rtl/byte_fetch_unit_pkg.sv | 18 +
 rtl/byte_fetch_unit_if.sv | 29 ++
 rtl/byte_fetch_unit_fetch_skid_buf.sv | 61 ++++++
 rtl/byte_fetch_unit.sv | 105 ++++++++++
 tb/tb_byte_fetch_unit.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/byte_fetch_unit_pkg.sv
// byte_fetch_unit_pkg: shared constants and types
// for the byte-serial instruction fetch path.
package byte_fetch_unit_pkg;

  localparam logic RstEnable = 1'b1;
  localparam logic True = 1'b1;
  localparam logic False = 1'b0;
  localparam int InstAddrBus = 32;
  localparam int ByteW = 8;
  localparam logic [InstAddrBus-1:0] ZeroWord = '0;

  typedef enum logic [1:0] {
    SK_EMPTY,
    SK_ONE,
    SK_TWO
  } skid_lvl_e;

endpackage

// File: rtl/byte_fetch_unit_if.sv
// byte_fetch_unit_if: RAM read port plus IF/ID byte stream.
// master = fetch unit, slave = RAM and byte assembler side.
interface byte_fetch_unit_if #(
  parameter int ADDR_W = byte_fetch_unit_pkg::InstAddrBus
);
  import byte_fetch_unit_pkg::*;

  logic              if_request;
  logic              jump;
  logic [ADDR_W-1:0] jump_target;
  logic [ByteW-1:0]  mem_dout;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_rd;
  logic [ByteW-1:0]  if_inst;
  logic [ADDR_W-1:0] if_pc;
  logic [1:0]        if_byte;
  logic              if_valid;

  modport master (
    input  if_request, jump, jump_target, mem_dout,
    output mem_a, mem_rd, if_inst, if_pc, if_byte, if_valid
  );

  modport slave (
    output if_request, jump, jump_target, mem_dout,
    input  mem_a, mem_rd, if_inst, if_pc, if_byte, if_valid
  );

endinterface

// File: rtl/byte_fetch_unit_fetch_skid_buf.sv
// fetch_skid_buf: small in-order skid store for returned bytes
// that the output register cannot take yet; flush empties it.
module fetch_skid_buf
  import byte_fetch_unit_pkg::*;
#(
  parameter int W = 40
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  skid_lvl_e  lvl;
  skid_lvl_e  lvl_n;
  logic [W-1:0] e0;
  logic [W-1:0] e1;
  logic push;
  logic pop;

  assign out_valid = (lvl != SK_EMPTY);
  assign out_data = e0;
  assign push = in_valid & (lvl != SK_TWO);
  assign pop = out_valid & out_ready;

  // fill-level register
  always_ff @(posedge clk) begin
    if (rst == RstEnable) lvl <= SK_EMPTY;
    else lvl <= lvl_n;
  end

  // next fill level from push/pop, flush wins
  always_comb begin
    lvl_n = lvl;
    unique case (lvl)
      SK_EMPTY: if (push) lvl_n = SK_ONE;
      SK_ONE: begin
        if (push & !pop) lvl_n = SK_TWO;
        else if (!push & pop) lvl_n = SK_EMPTY;
      end
      SK_TWO: if (pop) lvl_n = SK_ONE;
      default: lvl_n = SK_EMPTY;
    endcase
    if (flush) lvl_n = SK_EMPTY;
  end

  // entry storage: e0 is always the oldest byte
  always_ff @(posedge clk) begin
    if (pop) begin
      e0 <= (lvl == SK_TWO) ? e1 : in_data;
    end else if (push) begin
      if (lvl == SK_EMPTY) e0 <= in_data;
      else e1 <= in_data;
    end
  end

endmodule

// File: rtl/byte_fetch_unit.sv
// byte_fetch_unit: issues byte reads to the instruction RAM
// and streams one byte per cycle to the IF/ID assembler.
module byte_fetch_unit
  import byte_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = InstAddrBus,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic clk,
  input logic rst,
  byte_fetch_unit_if.master bus
);

  localparam int PW = ByteW + ADDR_W;

  logic [ADDR_W-1:0] iss_addr;
  logic [ADDR_W-1:0] tag;
  logic pending;
  logic acc;
  logic out_free;
  logic issue;
  logic sk_valid;
  logic sk_push;
  logic sk_pop;
  logic [PW-1:0] sk_out;
  logic [PW-1:0] ret;
  logic cap_valid;
  logic [PW-1:0] cap_data;
  logic [ADDR_W-1:0] cap_addr;

  assign acc = bus.if_valid & bus.if_request;
  assign out_free = !bus.if_valid | acc;
  assign issue = !bus.jump & bus.if_request
               & (!pending | out_free);
  assign ret = {bus.mem_dout, tag};
  assign sk_pop = out_free & sk_valid;
  assign sk_push = pending & (sk_valid | !out_free);

  fetch_skid_buf #(.W(PW)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.jump),
    .in_valid  (sk_push),
    .in_data   (ret),
    .out_valid (sk_valid),
    .out_ready (sk_pop),
    .out_data  (sk_out)
  );

  // pick the oldest byte available for the output register
  always_comb begin
    cap_valid = False;
    cap_data = sk_out;
    if (sk_valid) begin
      cap_valid = True;
    end else if (pending) begin
      cap_valid = True;
      cap_data = ret;
    end
  end

  assign cap_addr = cap_data[ADDR_W-1:0];

  // read issue, address pointer and in-flight tracking
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      bus.mem_rd <= False;
      bus.mem_a <= RESET_PC;
      iss_addr <= RESET_PC;
      pending <= False;
      tag <= RESET_PC;
    end else begin
      bus.mem_rd <= issue;
      pending <= bus.mem_rd & !bus.jump;
      tag <= bus.mem_a;
      if (issue) begin
        bus.mem_a <= iss_addr;
        iss_addr <= iss_addr + ADDR_W'(1);
      end
      if (bus.jump) begin
        iss_addr <= bus.jump_target & ~ADDR_W'(3);
      end
    end
  end

  // output register: load, hold or drain
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      bus.if_valid <= False;
      bus.if_inst <= ZeroWord[ByteW-1:0];
      bus.if_pc <= RESET_PC;
      bus.if_byte <= 2'd0;
    end else if (bus.jump) begin
      bus.if_valid <= False;
    end else if (out_free) begin
      bus.if_valid <= cap_valid;
      if (cap_valid) begin
        bus.if_inst <= cap_data[PW-1:ADDR_W];
        bus.if_pc <= cap_addr & ~ADDR_W'(3);
        bus.if_byte <= cap_addr[1:0];
      end
    end
  end

endmodule

// File: tb/tb_byte_fetch_unit.sv
// tb_byte_fetch_unit: directed vector table, wrap check on a
// second instance, and randomized stream checks.
module tb_byte_fetch_unit;

  logic clk = 1'b0;
  logic rst;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  byte_fetch_unit_if #(.ADDR_W(32)) bus ();
  byte_fetch_unit_if #(.ADDR_W(32)) bus2 ();

  byte_fetch_unit #(
    .ADDR_W(32), .RESET_PC(32'h0000_0000)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.master)
  );

  byte_fetch_unit #(
    .ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)
  ) dut2 (
    .clk(clk), .rst(rst), .bus(bus2.master)
  );

  function automatic logic [7:0] ram(input logic [31:0] a);
    case (a)
      32'd0: return 8'h13;
      32'd1: return 8'h05;
      32'd2: return 8'h10;
      32'd3: return 8'h00;
      32'd4: return 8'h93;
      default: return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'hA5;
    endcase
  endfunction

  always @(posedge clk)
    bus.mem_dout <= bus.mem_rd ? ram(bus.mem_a) : 8'($urandom);

  always @(posedge clk)
    bus2.mem_dout <= bus2.mem_rd ? ram(bus2.mem_a) : 8'($urandom);

  task automatic check(input string nm, input int idx,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h want %h", nm, idx, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        req;
    logic        jmp;
    logic [31:0] tgt;
    logic        rd;
    logic [31:0] a;
    logic        v;
    logic        chk;
    logic [7:0]  inst;
    logic [31:0] pc;
    logic [1:0]  bi;
  } vec_t;

  vec_t tab[$];

  task automatic add(input logic r, input logic q,
                     input logic j, input logic [31:0] t,
                     input logic rd, input logic [31:0] a,
                     input logic v, input logic c,
                     input logic [31:0] da);
    vec_t e;
    e.rst = r; e.req = q; e.jmp = j; e.tgt = t;
    e.rd = rd; e.a = a; e.v = v; e.chk = c;
    e.inst = r ? 8'h00 : ram(da);
    e.pc = da & ~32'd3;
    e.bi = da[1:0];
    tab.push_back(e);
  endtask

  logic [31:0] exp_addr;
  logic [31:0] wa;
  logic        prev_hold;
  logic        prev_jmp;
  logic [41:0] prev_out;
  logic        q;
  logic        j;
  logic [31:0] t;
  int          n_acc;

  initial begin
    rst = 1'b1;
    bus.if_request = 1'b0;
    bus.jump = 1'b0;
    bus.jump_target = '0;
    bus2.if_request = 1'b1;
    bus2.jump = 1'b0;
    bus2.jump_target = '0;

    // rst req jmp tgt | rd a v chk data-addr
    add(1, 0, 0, 0,      0, 0,      0, 1, 0);
    add(0, 1, 0, 0,      1, 0,      0, 0, 0);
    add(0, 1, 0, 0,      1, 1,      0, 0, 0);
    add(0, 1, 0, 0,      1, 2,      1, 1, 0);
    add(0, 1, 0, 0,      1, 3,      1, 1, 1);
    add(0, 0, 0, 0,      0, 3,      1, 1, 1);
    add(0, 0, 0, 0,      0, 3,      1, 1, 1);
    add(0, 0, 0, 0,      0, 3,      1, 1, 1);
    add(0, 1, 0, 0,      1, 4,      1, 1, 2);
    add(0, 1, 0, 0,      1, 5,      1, 1, 3);
    add(0, 1, 0, 0,      1, 6,      1, 1, 4);
    add(0, 1, 0, 0,      1, 7,      1, 1, 5);
    add(0, 1, 1, 'h40,   0, 7,      0, 0, 0);
    add(0, 1, 0, 0,      1, 'h40,   0, 0, 0);
    add(0, 1, 0, 0,      1, 'h41,   0, 0, 0);
    add(0, 1, 0, 0,      1, 'h42,   1, 1, 'h40);
    add(0, 1, 1, 'h102,  0, 'h42,   0, 0, 0);
    add(0, 1, 0, 0,      1, 'h100,  0, 0, 0);
    add(0, 1, 0, 0,      1, 'h101,  0, 0, 0);
    add(0, 1, 0, 0,      1, 'h102,  1, 1, 'h100);
    add(0, 1, 0, 0,      1, 'h103,  1, 1, 'h101);
    add(0, 0, 0, 0,      0, 'h103,  1, 1, 'h101);
    add(0, 1, 1, 'h201,  0, 'h103,  0, 0, 0);
    add(0, 1, 0, 0,      1, 'h200,  0, 0, 0);
    add(0, 1, 0, 0,      1, 'h201,  0, 0, 0);
    add(0, 1, 0, 0,      1, 'h202,  1, 1, 'h200);
    add(0, 1, 0, 0,      1, 'h203,  1, 1, 'h201);
    add(0, 1, 0, 0,      1, 'h204,  1, 1, 'h202);
    add(1, 1, 0, 0,      0, 0,      0, 1, 0);
    add(0, 1, 0, 0,      1, 0,      0, 0, 0);
    add(0, 1, 0, 0,      1, 1,      0, 0, 0);
    add(0, 1, 0, 0,      1, 2,      1, 1, 0);
    add(0, 1, 0, 0,      1, 3,      1, 1, 1);

    for (int i = 0; i < tab.size(); i++) begin
      rst = tab[i].rst;
      bus.if_request = tab[i].req;
      bus.jump = tab[i].jmp;
      bus.jump_target = tab[i].tgt;
      @(posedge clk);
      #1;
      check("mem_rd", i, 64'(bus.mem_rd), 64'(tab[i].rd));
      check("mem_a", i, 64'(bus.mem_a), 64'(tab[i].a));
      check("if_valid", i, 64'(bus.if_valid), 64'(tab[i].v));
      if (tab[i].chk)
        check("if_data", i,
              {22'd0, bus.if_inst, bus.if_pc, bus.if_byte},
              {22'd0, tab[i].inst, tab[i].pc, tab[i].bi});
      if (i >= 1 && i <= 8) begin
        wa = 32'hFFFF_FFFC + 32'(i - 1);
        check("wrap_a", i, 64'(bus2.mem_a), 64'(wa));
        if (i >= 3) begin
          wa = 32'hFFFF_FFFC + 32'(i - 3);
          check("wrap_out", i,
                {21'd0, bus2.if_valid, bus2.if_inst,
                 bus2.if_pc, bus2.if_byte},
                {21'd0, 1'b1, ram(wa), wa & ~32'd3, wa[1:0]});
        end
      end
    end

    rst = 1'b1;
    bus.if_request = 1'b0;
    bus.jump = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_addr = 32'h0;
    prev_hold = 1'b0;
    prev_jmp = 1'b0;
    prev_out = '0;
    n_acc = 0;
    for (int c = 0; c < 3000; c++) begin
      q = ($urandom_range(0, 9) < 7);
      j = ($urandom_range(0, 39) == 0);
      t = ($urandom_range(0, 3) == 0)
        ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
        : $urandom;
      if (prev_hold)
        check("hold", c,
              {22'd0, bus.if_valid, bus.if_inst,
               bus.if_pc, bus.if_byte},
              {22'd0, 1'b1, prev_out});
      if (prev_jmp)
        check("rd_after_jump", c, 64'(bus.mem_rd), 64'd0);
      if (bus.if_valid && q) begin
        check("stream", c,
              {24'd0, bus.if_inst, bus.if_pc | 32'(bus.if_byte)},
              {24'd0, ram(exp_addr), exp_addr});
        exp_addr = exp_addr + 32'd1;
        n_acc++;
      end
      if (j) exp_addr = t & ~32'd3;
      prev_hold = bus.if_valid && !q && !j;
      prev_jmp = j;
      prev_out = {bus.if_inst, bus.if_pc, bus.if_byte};
      bus.if_request = q;
      bus.jump = j;
      bus.jump_target = t;
      @(posedge clk);
      #1;
    end
    check("throughput", 0, 64'(n_acc > 1000), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
